fwd_scoreboard: RTL

Parametrised forwarding and stall unit for the multi-stage MIPS datapath, replacing the fixed single/double forward selects. It holds a shift-register scoreboard of in-flight register writes for every stage after Decode and, for each of `NREAD` Decode-stage read ports, picks the youngest matching producer's result or the register-file value. It raises `stall` when a producer's result will not be ready by the consumer's use stage. Sits beside the Decode stage; its operands feed the D/E pipeline register.

---
 rtl/fwd_pkg.sv | 30 +++
 rtl/fwd_port_match.sv | 64 ++++++
 rtl/fwd_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding scoreboard.
//   REG_ADDR_W : architectural register address width
//   TW         : width of the tnew/tuse timing fields
//   FWD_RF     : select code meaning "take the register-file value"
//   entry_t    : one tracked in-flight register write (valid, dst, tnew)
//   entry_age  : advance an entry by one stage (tnew counts down to 0)
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int TW         = 2;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic [TW-1:0]         tnew;
    } entry_t;

    // Cycles-until-result shrinks by one per stage and parks at zero once
    // the value is available on the stage's result bus.
    function automatic entry_t entry_age(input entry_t e);
        entry_t r;
        r = e;
        if (e.tnew != '0) begin
            r.tnew = e.tnew - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port producer search.
//   entries    : tracked writes, index 0 = E (youngest) .. DEPTH-1 (oldest)
//   rd_addr    : source register of this port
//   rd_tuse    : cycles after Decode until this port consumes its operand
//   rf_data    : register-file read data for this port
//   stage_data : result bus of each tracked stage, stage i at [i*DATA_W +: DATA_W]
//   operand    : selected operand
//   fwd_sel    : FWD_RF, or i+1 when forwarding from stage i
//   stall_req  : youngest producer cannot deliver in time
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input  entry_t [DEPTH-1:0]        entries,
    input  logic [REG_ADDR_W-1:0]     rd_addr,
    input  logic [TW-1:0]             rd_tuse,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [DATA_W-1:0]         operand,
    output logic [SEL_W-1:0]          fwd_sel,
    output logic                      stall_req
);

    logic              hit;
    logic [SEL_W-1:0]  hit_sel;
    logic [TW-1:0]     hit_tnew;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_tnew = '0;
        hit_data = '0;
        // Scan oldest to youngest so the youngest match overwrites the rest.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].dst == rd_addr && rd_addr != '0) begin
                hit      = 1'b1;
                hit_sel  = SEL_W'(i + 1);
                hit_tnew = entries[i].tnew;
                hit_data = stage_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        fwd_sel   = SEL_W'(FWD_RF);
        operand   = rf_data;
        stall_req = 1'b0;
        if (hit) begin
            if (hit_tnew == '0) begin
                fwd_sel = hit_sel;
                operand = hit_data;
            end else if (hit_tnew > rd_tuse) begin
                stall_req = 1'b1;
            end
            // 0 < tnew <= tuse: the value is picked up by a later stage's
            // forward select, so Decode passes the register-file value on.
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and stall unit beside the Decode stage.
//   clk, reset_n  : clock, asynchronous active-low reset
//   issue_valid   : Decode instruction attempts to advance into E
//   issue_wen     : issuing instruction writes a register
//   issue_dst     : its destination register
//   issue_tnew    : cycles after entering E until its result is on stage_data
//   flush         : kill every tracked entry
//   rd_addr       : source register per read port (5 bits each)
//   rd_tuse       : cycles after Decode until each port consumes its operand
//   rf_data       : register-file read data per port
//   stage_data    : result carried by the instruction in each tracked stage
//   operand       : selected operand per port
//   fwd_sel       : 0 = register file, i+1 = stage i, per port
//   stall         : hold Decode and insert a bubble into E
//
// Issue handshake: an instruction enters E on a clock edge where
// issue_valid=1 and stall=0; while stall=1 Decode holds it and stage 0
// receives a bubble. flush overrides both and empties the scoreboard.
module fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREAD  = 2,
    parameter int DEPTH  = 3,
    parameter int TW     = fwd_pkg::TW
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   issue_valid,
    input  logic                                   issue_wen,
    input  logic [4:0]                             issue_dst,
    input  logic [TW-1:0]                          issue_tnew,
    input  logic                                   flush,
    input  logic [NREAD*5-1:0]                     rd_addr,
    input  logic [NREAD*TW-1:0]                    rd_tuse,
    input  logic [NREAD*DATA_W-1:0]                rf_data,
    input  logic [DEPTH*DATA_W-1:0]                stage_data,
    output logic [NREAD*DATA_W-1:0]                operand,
    output logic [NREAD*$clog2(DEPTH+1)-1:0]       fwd_sel,
    output logic                                   stall
);

    import fwd_pkg::*;

    localparam int SEL_W = $clog2(DEPTH + 1);

    entry_t [DEPTH-1:0] entries;
    entry_t             issue_entry;
    logic [NREAD-1:0]   stall_req;

    // Non-writing instructions and writes to $0 are tracked as bubbles.
    always_comb begin
        issue_entry       = '0;
        issue_entry.valid = issue_valid && !stall && issue_wen && (issue_dst != '0);
        issue_entry.dst   = issue_dst;
        issue_entry.tnew  = issue_tnew;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entries <= '0;
        end else if (flush) begin
            entries <= '0;
        end else begin
            entries[0] <= issue_entry;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entry_age(entries[i-1]);
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_port_match #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_match (
            .entries    (entries),
            .rd_addr    (rd_addr[p*5 +: 5]),
            .rd_tuse    (rd_tuse[p*TW +: TW]),
            .rf_data    (rf_data[p*DATA_W +: DATA_W]),
            .stage_data (stage_data),
            .operand    (operand[p*DATA_W +: DATA_W]),
            .fwd_sel    (fwd_sel[p*SEL_W +: SEL_W]),
            .stall_req  (stall_req[p])
        );
    end

    // A flushed Decode instruction is dead, so it must not hold the pipe.
    assign stall = (|stall_req) && !flush;

endmodule
